// File: rtl/quad_telemetry_packetizer.sv
// quad_telemetry_packetizer: periodically snapshots the signed quadrature count
// and streams it as a framed byte packet through the async_transmitter
// TxD_start / TxD_data / TxD_busy handshake.
// Packet: SyncByte, seq, count[31:24], [23:16], [15:8], [7:0], XOR of bytes 1..last-1.
// Optional feature macro QUAD_PKT_VELOCITY_EN adds a saturated 16-bit velocity
// (snapshot - previous snapshot) before the checksum, giving a 9-byte packet.
module quad_telemetry_packetizer #(
    parameter int          ClkFrequency = 100000000,
    parameter int          ReportRate   = 100,
    parameter logic [7:0]  SyncByte     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] count,
    output logic        TxD_start,
    output logic [7:0]  TxD_data,
    input  logic        TxD_busy,
    output logic        pkt_done,
    output logic        overrun
);

    localparam int Period = ClkFrequency / ReportRate;
    localparam int TimerW = (Period > 1) ? $clog2(Period) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(Period - 1);

`ifdef QUAD_PKT_VELOCITY_EN
    localparam int NumBytes = 9;
`else
    localparam int NumBytes = 7;
`endif
    localparam logic [3:0] LastIndex = 4'(NumBytes - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_HI,
        WAIT_LO
    } stateT;

    stateT             state;
    stateT             nextState;
    logic [TimerW-1:0] timer;
    logic              tick;
    logic              pending;
    logic              accept;
    logic [7:0]        seq;
    logic [31:0]       snapshot;
    logic [3:0]        byteIdx;
    logic              hiWait;
    logic [7:0]        packetByte;
    logic [7:0]        checksum;
    logic              byteSent;

    assign tick     = enable && (timer == TimerLast);
    assign accept   = (state == IDLE) && pending;
    assign byteSent = (state == WAIT_LO) && !TxD_busy;
    // A tick coinciding with IDLE taking the pending request simply re-queues;
    // only a tick that would stack a second request is reported.
    assign overrun  = tick && pending && !accept;

`ifdef QUAD_PKT_VELOCITY_EN
    logic [31:0]        prevSnapshot;
    logic signed [32:0] diff;
    logic [15:0]        delta;

    // Velocity since the previous packet, clamped to the signed 16-bit range.
    always_comb begin
        diff  = $signed({snapshot[31], snapshot}) - $signed({prevSnapshot[31], prevSnapshot});
        delta = diff[15:0];
        if (diff > 33'sd32767) begin
            delta = 16'h7FFF;
        end else if (diff < -33'sd32768) begin
            delta = 16'h8000;
        end
    end

    // Remember the previous snapshot each time a new one is latched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prevSnapshot <= 32'h0;
        end else if (accept) begin
            prevSnapshot <= snapshot;
        end
    end
`endif

    // Select the packet byte for the current index; checksum covers bytes 1..last-1.
    always_comb begin
        checksum = seq ^ snapshot[31:24] ^ snapshot[23:16] ^ snapshot[15:8] ^ snapshot[7:0];
`ifdef QUAD_PKT_VELOCITY_EN
        checksum = checksum ^ delta[15:8] ^ delta[7:0];
`endif
        packetByte = 8'h00;
        case (byteIdx)
            4'd0: packetByte = SyncByte;
            4'd1: packetByte = seq;
            4'd2: packetByte = snapshot[31:24];
            4'd3: packetByte = snapshot[23:16];
            4'd4: packetByte = snapshot[15:8];
            4'd5: packetByte = snapshot[7:0];
`ifdef QUAD_PKT_VELOCITY_EN
            4'd6: packetByte = delta[15:8];
            4'd7: packetByte = delta[7:0];
            4'd8: packetByte = checksum;
`else
            4'd6: packetByte = checksum;
`endif
            default: packetByte = 8'h00;
        endcase
    end

    // Report timer: free-runs over one period while enabled, parked at zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (!enable || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + TimerW'(1);
        end
    end

    // Single-entry request queue between the timer and the packet engine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (tick) begin
            pending <= 1'b1;
        end else if (accept) begin
            pending <= 1'b0;
        end
    end

    // State register for the packet engine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Packet engine sequencing and the TxD_start / pkt_done strobes.
    always_comb begin
        nextState = state;
        TxD_start = 1'b0;
        pkt_done  = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    nextState = LOAD;
                end
            end
            LOAD: begin
                nextState = SEND;
            end
            SEND: begin
                if (!TxD_busy) begin
                    TxD_start = 1'b1;
                    nextState = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (TxD_busy) begin
                    nextState = WAIT_LO;
                end else if (hiWait) begin
                    nextState = SEND;
                end
            end
            WAIT_LO: begin
                if (!TxD_busy) begin
                    if (byteIdx == LastIndex) begin
                        pkt_done  = 1'b1;
                        nextState = IDLE;
                    end else begin
                        nextState = LOAD;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Second WAIT_HI cycle marker: busy never rose, so the start is treated as missed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hiWait <= 1'b0;
        end else begin
            hiWait <= (state == WAIT_HI) && !TxD_busy && !hiWait;
        end
    end

    // Packet datapath: snapshot capture, byte staging, index and sequence advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snapshot <= 32'h0;
            byteIdx  <= 4'd0;
            seq      <= 8'h00;
            TxD_data <= 8'h00;
        end else begin
            if (accept) begin
                snapshot <= count;
                byteIdx  <= 4'd0;
            end
            if (state == LOAD) begin
                TxD_data <= packetByte;
            end
            if (byteSent) begin
                if (byteIdx == LastIndex) begin
                    seq <= seq + 8'd1;
                end else begin
                    byteIdx <= byteIdx + 4'd1;
                end
            end
        end
    end

endmodule
